// File: rtl/res_station_array_if.sv
// rtl/res_station_array_if.sv - issue, CDB and dispatch bundle for the reservation station
interface res_station_array_if #(
    parameter int DATA_WIDTH = 16,
    parameter int TAG_WIDTH  = 3,
    parameter int OP_WIDTH   = 4,
    parameter int DEPTH      = 4
) ();
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic                  alloc_valid;
    logic                  alloc_ready;
    logic [OP_WIDTH-1:0]   alloc_op;
    logic [TAG_WIDTH-1:0]  alloc_dest;
    logic [DATA_WIDTH-1:0] alloc_Vj;
    logic [TAG_WIDTH-1:0]  alloc_Qj;
    logic                  alloc_Vj_valid;
    logic [DATA_WIDTH-1:0] alloc_Vk;
    logic [TAG_WIDTH-1:0]  alloc_Qk;
    logic                  alloc_Vk_valid;
    logic                  cdb_valid;
    logic [TAG_WIDTH-1:0]  cdb_tag;
    logic [DATA_WIDTH-1:0] cdb_data;
    logic                  issue_valid;
    logic                  issue_ready;
    logic [OP_WIDTH-1:0]   issue_op;
    logic [DATA_WIDTH-1:0] issue_Vj;
    logic [DATA_WIDTH-1:0] issue_Vk;
    logic [TAG_WIDTH-1:0]  issue_dest;
    logic [OCC_W-1:0]      occupancy;

    modport master (
        output alloc_valid, alloc_op, alloc_dest, alloc_Vj, alloc_Qj, alloc_Vj_valid,
        output alloc_Vk, alloc_Qk, alloc_Vk_valid, cdb_valid, cdb_tag, cdb_data, issue_ready,
        input  alloc_ready, issue_valid, issue_op, issue_Vj, issue_Vk, issue_dest, occupancy
    );

    modport slave (
        input  alloc_valid, alloc_op, alloc_dest, alloc_Vj, alloc_Qj, alloc_Vj_valid,
        input  alloc_Vk, alloc_Qk, alloc_Vk_valid, cdb_valid, cdb_tag, cdb_data, issue_ready,
        output alloc_ready, issue_valid, issue_op, issue_Vj, issue_Vk, issue_dest, occupancy
    );
endinterface

// File: rtl/res_station_array.sv
// rtl/res_station_array.sv - multi-entry Tomasulo reservation station with CDB wakeup
module res_station_array #(
    parameter int DATA_WIDTH = 16,
    parameter int TAG_WIDTH  = 3,
    parameter int OP_WIDTH   = 4,
    parameter int DEPTH      = 4
) (
    input  logic               clk,
    input  logic               flush,
    res_station_array_if.slave bus
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]                 r_busy;
    logic [DEPTH-1:0][OP_WIDTH-1:0]   r_op;
    logic [DEPTH-1:0][TAG_WIDTH-1:0]  r_dest;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] r_vj;
    logic [DEPTH-1:0][TAG_WIDTH-1:0]  r_qj;
    logic [DEPTH-1:0]                 r_vj_valid;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] r_vk;
    logic [DEPTH-1:0][TAG_WIDTH-1:0]  r_qk;
    logic [DEPTH-1:0]                 r_vk_valid;
    logic [OCC_W-1:0]                 r_occ;

    logic [DEPTH-1:0]      w_free;
    logic [DEPTH-1:0]      w_alloc_oh;
    logic [DEPTH-1:0]      w_ready;
    logic [DEPTH-1:0]      w_sel_oh;
    logic                  w_do_alloc;
    logic                  w_do_issue;
    logic                  w_byp_j;
    logic                  w_byp_k;
    logic [DATA_WIDTH-1:0] w_alloc_vj;
    logic [DATA_WIDTH-1:0] w_alloc_vk;
    logic [OP_WIDTH-1:0]   w_issue_op;
    logic [TAG_WIDTH-1:0]  w_issue_dest;
    logic [DATA_WIDTH-1:0] w_issue_vj;
    logic [DATA_WIDTH-1:0] w_issue_vk;

    // Lowest free slot and lowest ready slot as one-hot vectors (x & -x isolates the lowest set bit)
    always_comb begin
        w_free     = ~r_busy;
        w_alloc_oh = w_free & (~w_free + DEPTH'(1));
        w_ready    = r_busy & r_vj_valid & r_vk_valid;
        w_sel_oh   = w_ready & (~w_ready + DEPTH'(1));
        w_do_alloc = bus.alloc_valid && (|w_free);
        w_do_issue = (|w_ready) && bus.issue_ready;
        w_byp_j    = !bus.alloc_Vj_valid && bus.cdb_valid && (bus.cdb_tag == bus.alloc_Qj);
        w_byp_k    = !bus.alloc_Vk_valid && bus.cdb_valid && (bus.cdb_tag == bus.alloc_Qk);
        w_alloc_vj = w_byp_j ? bus.cdb_data : bus.alloc_Vj;
        w_alloc_vk = w_byp_k ? bus.cdb_data : bus.alloc_Vk;
    end

    // AND-OR mux of the selected entry; all zero when nothing is ready
    always_comb begin
        w_issue_op   = '0;
        w_issue_dest = '0;
        w_issue_vj   = '0;
        w_issue_vk   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_sel_oh[i]) begin
                w_issue_op   = r_op[i];
                w_issue_dest = r_dest[i];
                w_issue_vj   = r_vj[i];
                w_issue_vk   = r_vk[i];
            end
        end
    end

    assign bus.alloc_ready = |w_free;
    assign bus.issue_valid = |w_ready;
    assign bus.issue_op    = w_issue_op;
    assign bus.issue_dest  = w_issue_dest;
    assign bus.issue_Vj    = w_issue_vj;
    assign bus.issue_Vk    = w_issue_vk;
    assign bus.occupancy   = r_occ;

    // Entry update: flush, then allocate into a free slot, else dispatch-clear and CDB wakeup
    always_ff @(posedge clk) begin
        if (flush) begin
            r_busy     <= '0;
            r_op       <= '0;
            r_dest     <= '0;
            r_vj       <= '0;
            r_qj       <= '0;
            r_vj_valid <= '0;
            r_vk       <= '0;
            r_qk       <= '0;
            r_vk_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_do_alloc && w_alloc_oh[i]) begin
                    r_busy[i]     <= 1'b1;
                    r_op[i]       <= bus.alloc_op;
                    r_dest[i]     <= bus.alloc_dest;
                    r_vj[i]       <= w_alloc_vj;
                    r_qj[i]       <= bus.alloc_Qj;
                    r_vj_valid[i] <= bus.alloc_Vj_valid || w_byp_j;
                    r_vk[i]       <= w_alloc_vk;
                    r_qk[i]       <= bus.alloc_Qk;
                    r_vk_valid[i] <= bus.alloc_Vk_valid || w_byp_k;
                end else begin
                    if (w_do_issue && w_sel_oh[i]) begin
                        r_busy[i] <= 1'b0;
                    end
                    if (r_busy[i] && !r_vj_valid[i] && bus.cdb_valid && (r_qj[i] == bus.cdb_tag)) begin
                        r_vj[i]       <= bus.cdb_data;
                        r_vj_valid[i] <= 1'b1;
                    end
                    if (r_busy[i] && !r_vk_valid[i] && bus.cdb_valid && (r_qk[i] == bus.cdb_tag)) begin
                        r_vk[i]       <= bus.cdb_data;
                        r_vk_valid[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Occupancy tracks net alloc/dispatch; simultaneous events cancel
    always_ff @(posedge clk) begin
        if (flush) begin
            r_occ <= '0;
        end else if (w_do_alloc && !w_do_issue) begin
            r_occ <= r_occ + OCC_W'(1);
        end else if (!w_do_alloc && w_do_issue) begin
            r_occ <= r_occ - OCC_W'(1);
        end
    end
endmodule

// File: tb/tb_res_station_array.sv
// tb/tb_res_station_array.sv - directed self-checking bench for res_station_array
module tb_res_station_array;
    logic clk;
    logic flush;
    int   n_checks;
    int   n_errors;

    res_station_array_if #(.DATA_WIDTH(16), .TAG_WIDTH(3), .OP_WIDTH(4), .DEPTH(4)) rs_if ();

    res_station_array #(.DATA_WIDTH(16), .TAG_WIDTH(3), .OP_WIDTH(4), .DEPTH(4)) dut (
        .clk   (clk),
        .flush (flush),
        .bus   (rs_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs_if.alloc_valid    = 1'b0;
        rs_if.alloc_op       = '0;
        rs_if.alloc_dest     = '0;
        rs_if.alloc_Vj       = '0;
        rs_if.alloc_Qj       = '0;
        rs_if.alloc_Vj_valid = 1'b0;
        rs_if.alloc_Vk       = '0;
        rs_if.alloc_Qk       = '0;
        rs_if.alloc_Vk_valid = 1'b0;
        rs_if.cdb_valid      = 1'b0;
        rs_if.cdb_tag        = '0;
        rs_if.cdb_data       = '0;
    endtask

    task automatic put(input logic [3:0] op, input logic [2:0] dest,
                       input logic [15:0] vj, input logic [2:0] qj, input logic vjv,
                       input logic [15:0] vk, input logic [2:0] qk, input logic vkv);
        rs_if.alloc_valid    = 1'b1;
        rs_if.alloc_op       = op;
        rs_if.alloc_dest     = dest;
        rs_if.alloc_Vj       = vj;
        rs_if.alloc_Qj       = qj;
        rs_if.alloc_Vj_valid = vjv;
        rs_if.alloc_Vk       = vk;
        rs_if.alloc_Qk       = qk;
        rs_if.alloc_Vk_valid = vkv;
    endtask

    task automatic bcast(input logic [2:0] tag, input logic [15:0] data);
        rs_if.cdb_valid = 1'b1;
        rs_if.cdb_tag   = tag;
        rs_if.cdb_data  = data;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle();
        rs_if.issue_ready = 1'b0;
        flush = 1'b1;
        step();
        step();
        flush = 1'b0;

        // reset state
        check("rst_alloc_ready", 32'(rs_if.alloc_ready), 32'd1);
        check("rst_issue_valid", 32'(rs_if.issue_valid), 32'd0);
        check("rst_occupancy",   32'(rs_if.occupancy),   32'd0);
        check("rst_issue_vj",    32'(rs_if.issue_Vj),    32'd0);

        // 1) fully ready op dispatches the cycle after allocation
        rs_if.issue_ready = 1'b1;
        put(4'd1, 3'd2, 16'd5, 3'd0, 1'b1, 16'd7, 3'd0, 1'b1);
        step();
        idle();
        check("t1_valid", 32'(rs_if.issue_valid), 32'd1);
        check("t1_op",    32'(rs_if.issue_op),    32'd1);
        check("t1_vj",    32'(rs_if.issue_Vj),    32'd5);
        check("t1_vk",    32'(rs_if.issue_Vk),    32'd7);
        check("t1_dest",  32'(rs_if.issue_dest),  32'd2);
        check("t1_occ1",  32'(rs_if.occupancy),   32'd1);
        step();
        check("t1_occ0",   32'(rs_if.occupancy),   32'd0);
        check("t1_valid0", 32'(rs_if.issue_valid), 32'd0);

        // 2) wakeup through CDB two cycles after allocation
        put(4'd2, 3'd1, 16'd0, 3'd3, 1'b0, 16'd9, 3'd0, 1'b1);
        step();
        idle();
        check("t2_wait1", 32'(rs_if.issue_valid), 32'd0);
        step();
        bcast(3'd3, 16'h1234);
        check("t2_wait2", 32'(rs_if.issue_valid), 32'd0);
        step();
        idle();
        check("t2_valid", 32'(rs_if.issue_valid), 32'd1);
        check("t2_vj",    32'(rs_if.issue_Vj),    32'h1234);
        check("t2_vk",    32'(rs_if.issue_Vk),    32'd9);
        step();
        check("t2_occ0", 32'(rs_if.occupancy), 32'd0);

        // 3) allocation bypass from a same-cycle broadcast
        put(4'd3, 3'd5, 16'd1, 3'd0, 1'b1, 16'd0, 3'd4, 1'b0);
        bcast(3'd4, 16'hBEEF);
        step();
        idle();
        check("t3_valid", 32'(rs_if.issue_valid), 32'd1);
        check("t3_vk",    32'(rs_if.issue_Vk),    32'hBEEF);
        check("t3_dest",  32'(rs_if.issue_dest),  32'd5);
        step();
        check("t3_occ0", 32'(rs_if.occupancy), 32'd0);

        // 4) fill all entries while the FU stalls
        rs_if.issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put(4'd4, 3'(i), 16'(i + 10), 3'd0, 1'b1, 16'd0, 3'd0, 1'b1);
            step();
        end
        check("t4_full_ready", 32'(rs_if.alloc_ready), 32'd0);
        check("t4_full_occ",   32'(rs_if.occupancy),   32'd4);
        put(4'd9, 3'd7, 16'd99, 3'd0, 1'b1, 16'd0, 3'd0, 1'b1);
        step();
        check("t4_ignored_occ",  32'(rs_if.occupancy),  32'd4);
        check("t4_stall_valid",  32'(rs_if.issue_valid), 32'd1);
        check("t4_stall_dest",   32'(rs_if.issue_dest),  32'd0);
        check("t4_stall_vj",     32'(rs_if.issue_Vj),    32'd10);
        // dispatch while full: the alloc is dropped because alloc_ready was low pre-edge
        rs_if.issue_ready = 1'b1;
        put(4'd6, 3'd6, 16'h66, 3'd0, 1'b1, 16'd0, 3'd0, 1'b1);
        step();
        check("t4_freed_ready", 32'(rs_if.alloc_ready), 32'd1);
        check("t4_freed_occ",   32'(rs_if.occupancy),   32'd3);
        check("t4_freed_dest",  32'(rs_if.issue_dest),  32'd1);
        // simultaneous alloc into slot 0 and dispatch of slot 1
        step();
        idle();
        check("t4_refill_occ",  32'(rs_if.occupancy),  32'd3);
        check("t4_refill_dest", 32'(rs_if.issue_dest), 32'd6);
        check("t4_refill_vj",   32'(rs_if.issue_Vj),   32'h66);
        step();
        step();
        step();
        check("t4_drain_occ", 32'(rs_if.occupancy), 32'd0);

        // 5) out-of-order select: entry 0 waits on tag 0, entry 2 waits on tag 6
        rs_if.issue_ready = 1'b0;
        put(4'd5, 3'd0, 16'd0, 3'd0, 1'b0, 16'd20, 3'd0, 1'b1);
        step();
        put(4'd5, 3'd1, 16'd21, 3'd0, 1'b1, 16'd22, 3'd0, 1'b1);
        step();
        put(4'd5, 3'd2, 16'd0, 3'd6, 1'b0, 16'd23, 3'd0, 1'b1);
        step();
        put(4'd5, 3'd3, 16'd24, 3'd0, 1'b1, 16'd25, 3'd0, 1'b1);
        step();
        idle();
        check("t5_first_dest", 32'(rs_if.issue_dest), 32'd1);
        rs_if.issue_ready = 1'b1;
        step();
        check("t5_second_dest", 32'(rs_if.issue_dest), 32'd3);
        rs_if.issue_ready = 1'b0;
        bcast(3'd0, 16'h55AA);
        step();
        idle();
        check("t5_preempt_dest", 32'(rs_if.issue_dest), 32'd0);
        check("t5_preempt_vj",   32'(rs_if.issue_Vj),   32'h55AA);
        rs_if.issue_ready = 1'b1;
        step();
        check("t5_after_dest", 32'(rs_if.issue_dest), 32'd3);
        step();
        check("t5_pending_valid", 32'(rs_if.issue_valid), 32'd0);
        check("t5_pending_occ",   32'(rs_if.occupancy),   32'd1);

        // 6) flush beats alloc, wakeup and issue in the same cycle
        rs_if.issue_ready = 1'b0;
        put(4'd7, 3'd4, 16'd0, 3'd7, 1'b0, 16'd0, 3'd7, 1'b0);
        step();
        step();
        idle();
        check("t6_pre_occ", 32'(rs_if.occupancy), 32'd3);
        flush = 1'b1;
        rs_if.issue_ready = 1'b1;
        bcast(3'd6, 16'h7777);
        put(4'd8, 3'd5, 16'd1, 3'd0, 1'b1, 16'd2, 3'd0, 1'b1);
        step();
        flush = 1'b0;
        idle();
        check("t6_occ",         32'(rs_if.occupancy),   32'd0);
        check("t6_issue_valid", 32'(rs_if.issue_valid), 32'd0);
        check("t6_alloc_ready", 32'(rs_if.alloc_ready), 32'd1);
        check("t6_issue_vj",    32'(rs_if.issue_Vj),    32'd0);
        bcast(3'd6, 16'h7777);
        step();
        idle();
        check("t6_no_ghost_valid", 32'(rs_if.issue_valid), 32'd0);
        check("t6_no_ghost_occ",   32'(rs_if.occupancy),   32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
